lc3_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the LC-3 register/ALU/PC datapath.
- Fetches one instruction per handshake with instruction memory, loads IR, increments PC.
- Decodes IR and drives the datapath load/gate/select signals for the register-only subset: ADD, AND, NOT, LEA, BR, JMP/RET, JSR/JSRR.
- Sits beside `datapath` in the top level; memory-class opcodes (LD/ST/LDR/STR/LDI/STI/TRAP/RTI) are reported as illegal.

---
 rtl/lc3_pkg.sv | 48 ++++
 rtl/lc3_decode.sv | 44 ++++
 rtl/lc3_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lc3_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// ============================================================
// Module : lc3_pkg
// Brief  : Shared opcodes, datapath select encodings and FSM states
// Rev    : 1.0
// ============================================================
`default_nettype none

package lc3_pkg;

  localparam logic [3:0] c_op_br  = 4'b0000;
  localparam logic [3:0] c_op_add = 4'b0001;
  localparam logic [3:0] c_op_jsr = 4'b0100;
  localparam logic [3:0] c_op_and = 4'b0101;
  localparam logic [3:0] c_op_not = 4'b1001;
  localparam logic [3:0] c_op_jmp = 4'b1100;
  localparam logic [3:0] c_op_lea = 4'b1110;

  localparam logic [1:0] c_aluk_pass = 2'b00;
  localparam logic [1:0] c_aluk_and  = 2'b01;
  localparam logic [1:0] c_aluk_add  = 2'b10;
  localparam logic [1:0] c_aluk_not  = 2'b11;

  localparam logic [1:0] c_a2m_zero  = 2'b00;
  localparam logic [1:0] c_a2m_off6  = 2'b01;
  localparam logic [1:0] c_a2m_off9  = 2'b10;
  localparam logic [1:0] c_a2m_off11 = 2'b11;

  localparam logic [1:0] c_pcmux_inc   = 2'b00;
  localparam logic [1:0] c_pcmux_bus   = 2'b01;
  localparam logic [1:0] c_pcmux_adder = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ALU    = 4'd3,
    S_LEA    = 4'd4,
    S_BR     = 4'd5,
    S_JMP    = 4'd6,
    S_JSR1   = 4'd7,
    S_JSR2   = 4'd8,
    S_RETIRE = 4'd9,
    S_FAULT  = 4'd10
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/lc3_decode.sv
// ============================================================
// Module : lc3_decode
// Brief  : Combinational IR decode to execute state, ALU op, legality
// Rev    : 1.0
// ============================================================
`default_nettype none

module lc3_decode
  import lc3_pkg::*;
(
  input  logic [15:0]  ir,
  output ctrl_state_t  next_state,
  output logic [1:0]   aluk,
  output logic         legal
);

  logic w_unused_ir;
  assign w_unused_ir = ^{ir[10:9], ir[5:0]};

  always_comb begin
    next_state = S_FAULT;
    aluk       = c_aluk_pass;
    legal      = 1'b0;
    case (ir[15:12])
      c_op_add: begin next_state = S_ALU; aluk = c_aluk_add; legal = 1'b1; end
      c_op_and: begin next_state = S_ALU; aluk = c_aluk_and; legal = 1'b1; end
      c_op_not: begin next_state = S_ALU; aluk = c_aluk_not; legal = 1'b1; end
      c_op_lea: begin next_state = S_LEA;  legal = 1'b1; end
      c_op_br:  begin next_state = S_BR;   legal = 1'b1; end
      c_op_jmp: begin next_state = S_JMP;  legal = 1'b1; end
      c_op_jsr: begin
        // JSRR through R7 would read the link register after JSR1 has overwritten it
        if (ir[11] || (ir[8:6] != 3'd7)) begin
          next_state = S_JSR1;
          legal      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lc3_ctrl.sv
// ============================================================
// Module : lc3_ctrl
// Brief  : LC-3 multi-cycle control FSM for the register-only subset
// Rev    : 1.0
// ============================================================
`default_nettype none

module lc3_ctrl
  import lc3_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 255,
  parameter int RETIRE_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [15:0]         ir,
  input  logic [2:0]          nzp,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                ld_ir,
  output logic                ld_reg,
  output logic                ld_pc,
  output logic                ld_cc,
  output logic [2:0]          dr,
  output logic [2:0]          sr1,
  output logic [2:0]          sr2,
  output logic [1:0]          aluk,
  output logic                gate_alu,
  output logic                gate_pc,
  output logic                gate_marmux,
  output logic                a1m_sel,
  output logic [1:0]          a2m_sel,
  output logic [1:0]          pcmux_sel,
  output logic                marmux_sel,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  localparam int unsigned TO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [TO_W-1:0] c_to_last = TO_W'(FETCH_TIMEOUT - 1);

  ctrl_state_t         r_state;
  ctrl_state_t         w_next;
  ctrl_state_t         w_dec_next;
  logic [1:0]          w_dec_aluk;
  logic                w_dec_legal;
  logic [TO_W-1:0]     r_to_cnt;
  logic                w_timeout;
  logic                w_br_taken;
  logic [RETIRE_W-1:0] r_retired;

  lc3_decode u_decode (
    .ir         (ir),
    .next_state (w_dec_next),
    .aluk       (w_dec_aluk),
    .legal      (w_dec_legal)
  );

  assign w_timeout  = (FETCH_TIMEOUT != 0) && (r_to_cnt == c_to_last);
  assign w_br_taken = |(ir[11:9] & nzp);
  assign retired    = r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      // Counter only advances while stalled in FETCH, so it is zero on every entry
      if ((r_state == S_FETCH) && !imem_ack)
        r_to_cnt <= r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;
      if (r_state == S_RETIRE)
        r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)       w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: w_next = w_dec_legal ? w_dec_next : S_FAULT;
      S_ALU, S_LEA, S_BR, S_JMP, S_JSR2: w_next = S_RETIRE;
      S_JSR1:   w_next = S_JSR2;
      S_RETIRE: w_next = run ? S_FETCH : S_IDLE;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    ld_ir       = 1'b0;
    ld_reg      = 1'b0;
    ld_pc       = 1'b0;
    ld_cc       = 1'b0;
    dr          = 3'd0;
    sr1         = 3'd0;
    sr2         = 3'd0;
    aluk        = c_aluk_pass;
    gate_alu    = 1'b0;
    gate_pc     = 1'b0;
    gate_marmux = 1'b0;
    a1m_sel     = 1'b0;
    a2m_sel     = c_a2m_zero;
    pcmux_sel   = c_pcmux_inc;
    marmux_sel  = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ld_ir     = 1'b1;
          ld_pc     = 1'b1;
          pcmux_sel = c_pcmux_inc;
        end
      end
      S_ALU: begin
        dr       = ir[11:9];
        sr1      = ir[8:6];
        sr2      = ir[2:0];
        aluk     = w_dec_aluk;
        gate_alu = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
      end
      S_LEA: begin
        dr          = ir[11:9];
        a1m_sel     = 1'b0;
        a2m_sel     = c_a2m_off9;
        marmux_sel  = 1'b1;
        gate_marmux = 1'b1;
        ld_reg      = 1'b1;
      end
      S_BR: begin
        if (w_br_taken) begin
          ld_pc     = 1'b1;
          pcmux_sel = c_pcmux_adder;
          a1m_sel   = 1'b0;
          a2m_sel   = c_a2m_off9;
        end
      end
      S_JMP: begin
        sr1       = ir[8:6];
        a1m_sel   = 1'b1;
        a2m_sel   = c_a2m_zero;
        pcmux_sel = c_pcmux_adder;
        ld_pc     = 1'b1;
      end
      S_JSR1: begin
        gate_pc = 1'b1;
        ld_reg  = 1'b1;
        dr      = 3'd7;
      end
      S_JSR2: begin
        ld_pc     = 1'b1;
        pcmux_sel = c_pcmux_adder;
        if (ir[11]) begin
          a1m_sel = 1'b0;
          a2m_sel = c_a2m_off11;
        end else begin
          sr1     = ir[8:6];
          a1m_sel = 1'b1;
          a2m_sel = c_a2m_zero;
        end
      end
      S_FAULT: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lc3_ctrl.sv
// ============================================================
// Module : tb_lc3_ctrl
// Brief  : Directed self-checking bench for lc3_ctrl
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_lc3_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        run_a = 1'b0, ack_a = 1'b0, run_b = 1'b0, ack_b = 1'b0;
  logic [15:0] ir_a = '0, ir_b = '0;
  logic [2:0]  nzp = '0;

  logic        req_a, ld_ir_a, ld_reg_a, ld_pc_a, ld_cc_a, gate_alu_a, gate_pc_a, gate_marmux_a;
  logic        a1m_a, marmux_a, ill_a;
  logic [2:0]  dr_a, sr1_a, sr2_a;
  logic [1:0]  aluk_a, a2m_a, pcmux_a;
  logic [15:0] ret_a;

  logic        req_b, ld_ir_b, ld_reg_b, ld_pc_b, ld_cc_b, gate_alu_b, gate_pc_b, gate_marmux_b;
  logic        a1m_b, marmux_b, ill_b;
  logic [2:0]  dr_b, sr1_b, sr2_b;
  logic [1:0]  aluk_b, a2m_b, pcmux_b;
  logic [1:0]  ret_b;

  logic [25:0] outs_a, outs_b;
  assign outs_a = {req_a, ld_ir_a, ld_reg_a, ld_pc_a, ld_cc_a, dr_a, sr1_a, sr2_a, aluk_a,
                   gate_alu_a, gate_pc_a, gate_marmux_a, a1m_a, a2m_a, pcmux_a, marmux_a, ill_a};
  assign outs_b = {req_b, ld_ir_b, ld_reg_b, ld_pc_b, ld_cc_b, dr_b, sr1_b, sr2_b, aluk_b,
                   gate_alu_b, gate_pc_b, gate_marmux_b, a1m_b, a2m_b, pcmux_b, marmux_b, ill_b};

  lc3_ctrl #(.FETCH_TIMEOUT(255), .RETIRE_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .ir(ir_a), .nzp(nzp),
    .imem_req(req_a), .imem_ack(ack_a),
    .ld_ir(ld_ir_a), .ld_reg(ld_reg_a), .ld_pc(ld_pc_a), .ld_cc(ld_cc_a),
    .dr(dr_a), .sr1(sr1_a), .sr2(sr2_a), .aluk(aluk_a),
    .gate_alu(gate_alu_a), .gate_pc(gate_pc_a), .gate_marmux(gate_marmux_a),
    .a1m_sel(a1m_a), .a2m_sel(a2m_a), .pcmux_sel(pcmux_a), .marmux_sel(marmux_a),
    .illegal(ill_a), .retired(ret_a)
  );

  lc3_ctrl #(.FETCH_TIMEOUT(4), .RETIRE_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .ir(ir_b), .nzp(nzp),
    .imem_req(req_b), .imem_ack(ack_b),
    .ld_ir(ld_ir_b), .ld_reg(ld_reg_b), .ld_pc(ld_pc_b), .ld_cc(ld_cc_b),
    .dr(dr_b), .sr1(sr1_b), .sr2(sr2_b), .aluk(aluk_b),
    .gate_alu(gate_alu_b), .gate_pc(gate_pc_b), .gate_marmux(gate_marmux_b),
    .a1m_sel(a1m_b), .a2m_sel(a2m_b), .pcmux_sel(pcmux_b), .marmux_sel(marmux_b),
    .illegal(ill_b), .retired(ret_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Called in a FETCH cycle; returns in the first execute-state cycle
  task automatic fetch_a(input logic [15:0] instr);
    chk("fetch_req", 32'(req_a), 32'd1);
    ack_a = 1'b1;
    ir_a  = instr;
    #1;
    chk("fetch_ld", 32'({ld_ir_a, ld_pc_a, pcmux_a}), 32'b1100);
    cyc();
    ack_a = 1'b0;
    #1;
    chk("decode_quiet", 32'(outs_a), 32'd0);
    cyc();
  endtask

  initial begin
    int reqs;
    #12;
    chk("reset_outs_a", 32'(outs_a), 32'd0);
    chk("reset_ret_a", 32'(ret_a), 32'd0);
    chk("reset_outs_b", 32'(outs_b), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc(2);
    chk("idle_no_run", 32'(outs_a), 32'd0);
    run_a = 1'b1;
    cyc();

    // ADD R5,R5,R6
    fetch_a(16'h1B46);
    chk("add_sel", 32'({dr_a, sr1_a, sr2_a}), 32'({3'd5, 3'd5, 3'd6}));
    chk("add_ctl", 32'({aluk_a, gate_alu_a, ld_reg_a, ld_cc_a, gate_pc_a, gate_marmux_a, ld_pc_a}), 32'b10_111_000);
    cyc();
    chk("retire_quiet", 32'(outs_a), 32'd0);
    cyc();
    chk("add_retired", 32'(ret_a), 32'd1);

    // BRz taken then not taken
    nzp = 3'b010;
    fetch_a(16'h0402);
    chk("br_taken", 32'({ld_pc_a, pcmux_a, a1m_a, a2m_a}), 32'b1_10_0_10);
    chk("br_nogate", 32'({gate_alu_a, gate_pc_a, gate_marmux_a, ld_reg_a, ld_cc_a}), 32'd0);
    cyc(2);
    chk("br_retired", 32'(ret_a), 32'd2);
    nzp = 3'b001;
    fetch_a(16'h0402);
    chk("br_not_taken", 32'(outs_a), 32'd0);
    cyc(2);
    chk("brn_retired", 32'(ret_a), 32'd3);

    // JSR PC+5
    fetch_a(16'h4805);
    chk("jsr1", 32'({gate_pc_a, ld_reg_a, dr_a, ld_pc_a, gate_alu_a}), 32'b11_111_00);
    cyc();
    chk("jsr2", 32'({ld_pc_a, pcmux_a, a1m_a, a2m_a, gate_pc_a, ld_reg_a}), 32'b1_10_0_11_00);
    cyc(2);
    chk("jsr_retired", 32'(ret_a), 32'd4);

    // LEA R1
    fetch_a(16'hE201);
    chk("lea", 32'({gate_marmux_a, marmux_a, ld_reg_a, dr_a, a1m_a, a2m_a, ld_cc_a, gate_alu_a}),
        32'b111_001_0_10_00);
    cyc(2);

    // JMP R3
    fetch_a(16'hC0C0);
    chk("jmp", 32'({ld_pc_a, pcmux_a, a1m_a, a2m_a, sr1_a, ld_reg_a}), 32'b1_10_1_00_011_0);
    cyc(2);

    // AND R2,R3,R4
    fetch_a(16'h54C4);
    chk("and", 32'({dr_a, sr1_a, sr2_a, aluk_a}), 32'b010_011_100_01);
    cyc(2);

    // NOT R1,R2 with run dropped mid-instruction
    fetch_a(16'h92BF);
    chk("not", 32'({dr_a, sr1_a, aluk_a}), 32'b001_010_11);
    run_a = 1'b0;
    cyc(2);
    chk("run_drop_idle", 32'(req_a), 32'd0);
    chk("run_drop_retired", 32'(ret_a), 32'd8);
    cyc();
    chk("run_drop_stays", 32'(outs_a), 32'd0);
    run_a = 1'b1;
    cyc();

    // Reset in the middle of an ALU cycle
    fetch_a(16'h1B46);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", 32'(outs_a), 32'd0);
    chk("midreset_ret", 32'(ret_a), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // JSRR R7 is rejected
    fetch_a(16'h41C0);
    chk("jsrr7_fault", 32'(outs_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("fault_clear", 32'(ill_a), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // LD is illegal; fault is sticky under run=1
    fetch_a(16'h2000);
    for (int i = 0; i < 20; i++) begin
      chk("ld_fault_sticky", 32'(outs_a), 32'd1);
      cyc();
    end
    rst_n = 1'b0;
    #1;
    chk("ld_fault_clear", 32'(ill_a), 32'd0);
    run_a = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Fetch timeout of 4 cycles on the second instance
    run_b = 1'b1;
    cyc();
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_b) reqs++;
      cyc();
    end
    chk("timeout_req_cycles", 32'(reqs), 32'd4);
    chk("timeout_fault", 32'(outs_b), 32'd1);
    rst_n = 1'b0;
    #1;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Retired counter wrap at 2 bits
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("ret_b_before_wrap", 32'(ret_b), 32'd3);
      ack_b = 1'b1;
      ir_b  = 16'h1B46;
      cyc();
      ack_b = 1'b0;
      cyc(3);
    end
    chk("ret_b_wrap", 32'(ret_b), 32'd0);
    chk("ret_b_fetching", 32'(req_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
